// File: rtl/logic_unit.sv
// Two-stage valid/ready bitwise logic unit with result flags and a handshake counter.
// Build option LOGIC_UNIT_REDUCE_EN turns op 111 into an AND-reduction of a (otherwise b passes through).
module logic_unit #(
    parameter int WIDTH = 8
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [2:0]       op,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [WIDTH-1:0] y,
    output logic             zero,
    output logic             parity,
    output logic [15:0]      done_cnt
);

    logic             v1;
    logic             v2;
    logic [2:0]       op1;
    logic [WIDTH-1:0] a1;
    logic [WIDTH-1:0] b1;
    logic [WIDTH-1:0] y_next;
    logic             ready1;
    logic             ready2;

    assign ready2    = !v2 || out_ready;
    assign ready1    = !v1 || ready2;
    // Reset masks both handshake signals so nothing transfers or counts while rst is high.
    assign in_ready  = ready1 && !rst;
    assign out_valid = v2 && !rst;

    always_comb begin
        y_next = '0;
        case (op1)
            3'b000:  y_next = a1 & b1;
            3'b001:  y_next = a1 | b1;
            3'b010:  y_next = a1 ^ b1;
            3'b011:  y_next = ~(a1 & b1);
            3'b100:  y_next = ~(a1 | b1);
            3'b101:  y_next = ~(a1 ^ b1);
            3'b110:  y_next = ~a1;
            default: begin
`ifdef LOGIC_UNIT_REDUCE_EN
                y_next    = '0;
                y_next[0] = &a1;
`else
                y_next = b1;
`endif
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            v1       <= 1'b0;
            v2       <= 1'b0;
            y        <= '0;
            zero     <= 1'b0;
            parity   <= 1'b0;
            done_cnt <= '0;
        end else begin
            if (ready1) begin
                v1 <= in_valid;
                if (in_valid) begin
                    op1 <= op;
                    a1  <= a;
                    b1  <= b;
                end
            end
            if (ready2) begin
                v2 <= v1;
                if (v1) begin
                    y      <= y_next;
                    zero   <= (y_next == '0);
                    parity <= ^y_next;
                end
            end
            if (v2 && out_ready) begin
                done_cnt <= done_cnt + 16'd1;
            end
        end
    end

endmodule

// File: tb/tb_logic_unit.sv
// Self-checking bench for logic_unit: directed vector table, stall/reset sequences,
// randomized traffic against a queue-based reference model, and counter wrap.
module tb_logic_unit;
    localparam int W = 8;

    logic         clk = 1'b0;
    logic         rst = 1'b1;
    logic         in_valid = 1'b0;
    logic         out_ready = 1'b0;
    logic [2:0]   op = 3'b000;
    logic [W-1:0] a = '0;
    logic [W-1:0] b = '0;
    logic         in_ready;
    logic         out_valid;
    logic [W-1:0] y;
    logic         zero;
    logic         parity;
    logic [15:0]  done_cnt;

    logic_unit #(.WIDTH(W)) dut (
        .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(in_ready),
        .op(op), .a(a), .b(b), .out_valid(out_valid), .out_ready(out_ready),
        .y(y), .zero(zero), .parity(parity), .done_cnt(done_cnt)
    );

    always #5 clk = ~clk;

    int total = 0;
    int bad = 0;

    logic [W-1:0] q[$];
    logic [15:0]  mcnt = '0;
    bit           initd = 0;
    logic         pv = 1'b0;
    logic         pr = 1'b0;
    logic [W-1:0] py = '0;
    logic         pz = 1'b0;
    logic         pp = 1'b0;
    logic         in_fire;
    logic         out_fire;
    int           n_in = 0;
    int           n_out = 0;

    typedef struct {
        logic [2:0]   op;
        logic [W-1:0] a;
        logic [W-1:0] b;
        logic [W-1:0] y;
    } vec_t;

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    function automatic logic [W-1:0] ref_y(input logic [2:0] o, input logic [W-1:0] x, input logic [W-1:0] z);
        logic [W-1:0] all1;
        all1 = '1;
        case (o)
            3'd0: return x & z;
            3'd1: return x | z;
            3'd2: return x ^ z;
            3'd3: return all1 - (x & z);
            3'd4: return all1 - (x | z);
            3'd5: return all1 - (x ^ z);
            3'd6: return all1 - x;
            default: begin
`ifdef LOGIC_UNIT_REDUCE_EN
                return (x == all1) ? W'(1) : W'(0);
`else
                return z;
`endif
            end
        endcase
    endfunction

    function automatic logic ref_par(input logic [W-1:0] v);
        return logic'($countones(v) % 2);
    endfunction

    // One clock cycle: sample away from the edge, score, then advance past the next edge.
    task automatic tick();
        logic [W-1:0] e;
        #1;
        in_fire  = !rst && in_valid && in_ready;
        out_fire = !rst && out_valid && out_ready;
        if (initd) begin
            check("done_cnt", done_cnt, mcnt);
            if (rst) begin
                check("rst_in_ready", in_ready, 0);
                check("rst_out_valid", out_valid, 0);
            end else begin
                check("in_ready", in_ready, !(q.size() == 2 && !out_ready));
                if (pv && !pr) begin
                    check("hold_valid", out_valid, 1);
                    check("hold_y", y, py);
                    check("hold_zero", zero, pz);
                    check("hold_parity", parity, pp);
                end
                if (out_fire) begin
                    if (q.size() == 0) begin
                        total++;
                        bad++;
                        $display("FAIL sb_underflow: got beat y=%0h expected none", y);
                    end else begin
                        e = q.pop_front();
                        check("sb_y", y, e);
                        check("sb_zero", zero, e == '0);
                        check("sb_parity", parity, ref_par(e));
                    end
                end
            end
        end
        pv = out_valid && !rst;
        pr = out_ready;
        py = y;
        pz = zero;
        pp = parity;
        if (rst) begin
            q.delete();
            mcnt  = '0;
            initd = 1;
        end else begin
            if (in_fire) q.push_back(ref_y(op, a, b));
            if (out_fire) mcnt++;
            n_in  += int'(in_fire);
            n_out += int'(out_fire);
        end
        @(posedge clk);
        #1;
    endtask

    vec_t vt[$];
    vec_t sv[3];

    initial begin
        int k;
        int start;
        logic [W-1:0] frozen;
        logic [W-1:0] exp7;
        logic [W-1:0] exp77;

`ifdef LOGIC_UNIT_REDUCE_EN
        exp7  = 8'h00;
        exp77 = 8'h01;
`else
        exp7  = 8'h0F;
        exp77 = 8'h0F;
`endif
        vt.push_back('{3'd0, 8'hA5, 8'h0F, 8'h05});
        vt.push_back('{3'd1, 8'hA5, 8'h0F, 8'hAF});
        vt.push_back('{3'd2, 8'hA5, 8'h0F, 8'hAA});
        vt.push_back('{3'd3, 8'hA5, 8'h0F, 8'hFA});
        vt.push_back('{3'd4, 8'hA5, 8'h0F, 8'h50});
        vt.push_back('{3'd5, 8'hA5, 8'h0F, 8'h55});
        vt.push_back('{3'd6, 8'hA5, 8'h0F, 8'h5A});
        vt.push_back('{3'd7, 8'hA5, 8'h0F, exp7});
        vt.push_back('{3'd2, 8'h77, 8'h77, 8'h00});
        vt.push_back('{3'd7, 8'hFF, 8'h0F, exp77});
        vt.push_back('{3'd6, 8'h00, 8'h12, 8'hFF});
        vt.push_back('{3'd1, 8'h00, 8'h00, 8'h00});
        vt.push_back('{3'd0, 8'hF0, 8'h3C, 8'h30});

        // Reset state
        tick();
        tick();
        check("rst_y", y, 0);
        check("rst_zero", zero, 0);
        check("rst_parity", parity, 0);
        check("rst_cnt", done_cnt, 0);
        rst = 1'b0;
        #1;
        check("post_rst_in_ready", in_ready, 1);

        // Two-cycle latency
        out_ready = 1'b1;
        in_valid = 1'b1; op = 3'd0; a = 8'hF0; b = 8'h3C;
        tick();
        in_valid = 1'b0;
        check("lat_n1_valid", out_valid, 0);
        tick();
        check("lat_n2_valid", out_valid, 1);
        check("lat_y", y, 8'h30);
        check("lat_zero", zero, 0);
        check("lat_parity", parity, 0);
        tick();

        // Back-to-back table with no bubbles
        for (int i = 0; i < vt.size() + 2; i++) begin
            if (i < vt.size()) begin
                in_valid = 1'b1; op = vt[i].op; a = vt[i].a; b = vt[i].b;
            end else begin
                in_valid = 1'b0;
            end
            #1;
            check("tbl_valid", out_valid, i >= 2);
            if (i >= 2) begin
                check("tbl_y", y, vt[i-2].y);
                check("tbl_zero", zero, vt[i-2].y == '0);
                check("tbl_parity", parity, ref_par(vt[i-2].y));
            end
            tick();
        end

        // Stall: three beats offered, consumer blocked for five cycles
        sv[0] = '{3'd0, 8'hFF, 8'h81, 8'h81};
        sv[1] = '{3'd1, 8'h10, 8'h01, 8'h11};
        sv[2] = '{3'd2, 8'hF0, 8'h0F, 8'hFF};
        out_ready = 1'b0;
        k = 0;
        frozen = '0;
        for (int c = 0; c < 5; c++) begin
            in_valid = (k < 3);
            if (k < 3) begin op = sv[k].op; a = sv[k].a; b = sv[k].b; end
            tick();
            if (in_fire) k++;
            if (c == 2) frozen = y;
        end
        check("stall_accepted", k, 2);
        check("stall_in_ready", in_ready, 0);
        check("stall_frozen", y, frozen);
        check("stall_head", y, sv[0].y);
        start = n_out;
        out_ready = 1'b1;
        for (int c = 0; c < 12 && !(k == 3 && q.size() == 0); c++) begin
            in_valid = (k < 3);
            if (k < 3) begin op = sv[k].op; a = sv[k].a; b = sv[k].b; end
            tick();
            if (in_fire) k++;
        end
        in_valid = 1'b0;
        check("stall_drained", n_out - start, 3);

        // Randomized traffic
        for (int c = 0; c < 400; c++) begin
            in_valid  = logic'($urandom_range(0, 3) != 0);
            out_ready = logic'($urandom_range(0, 2) != 0);
            op = 3'($urandom);
            a  = 8'($urandom);
            b  = 8'($urandom);
            if ($urandom_range(0, 7) == 0) a = 8'hFF;
            tick();
        end
        in_valid  = 1'b0;
        out_ready = 1'b1;
        for (int c = 0; c < 4; c++) tick();
        check("rand_drained", q.size(), 0);

        // Reset with two beats in flight
        out_ready = 1'b0;
        in_valid = 1'b1; op = 3'd1; a = 8'h01; b = 8'h02;
        tick();
        a = 8'h04;
        tick();
        in_valid = 1'b0;
        check("mid_full", out_valid, 1);
        rst = 1'b1;
        tick();
        rst = 1'b0;
        #1;
        check("mid_out_valid", out_valid, 0);
        check("mid_done_cnt", done_cnt, 0);
        out_ready = 1'b1;
        for (int c = 0; c < 4; c++) begin
            #1;
            check("mid_no_ghost", out_valid, 0);
            tick();
        end
        in_valid = 1'b1; op = 3'd4; a = 8'h0F; b = 8'h30;
        tick();
        in_valid = 1'b0;
        tick();
        check("mid_first_valid", out_valid, 1);
        check("mid_first_y", y, 8'hC0);
        tick();

        // Counter wrap after 65537 output handshakes
        rst = 1'b1;
        tick();
        rst = 1'b0;
        start = n_in;
        k = n_out;
        out_ready = 1'b1;
        for (int c = 0; c < 65600 && (n_out - k) < 65537; c++) begin
            in_valid = (n_in - start) < 65537;
            op = 3'($urandom);
            a  = 8'($urandom);
            b  = 8'($urandom);
            tick();
        end
        in_valid = 1'b0;
        check("wrap_count", n_out - k, 65537);
        check("wrap_done_cnt", done_cnt, 16'h0001);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
